// File: rtl/platform_pio_pkg.sv
// Shared types for the PIO Avalon-MM initiator: command/status codes, FSM states, PIO register map.
package platform_pio_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_POLL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_BADOP   = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_A,
    S_RD_C,
    S_GAP,
    S_RESP
  } state_e;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_DIR  = 2'd1;

endpackage

// File: rtl/platform_pio_poll_timer.sv
// Poll pacing: gap down-counter between reads and saturating read-attempt counter.
// Counters update one cycle after their control strobes; flags are pure decodes of the counters.
module platform_pio_poll_timer #(
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  input  logic gap_load,
  input  logic gap_run,
  output logic gap_done,
  output logic last_attempt,
  output logic attempts_exhausted
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam int GAP_W = $clog2(POLL_GAP + 1);

  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] attempts;

  // Gap counter is reloaded every time GAP is entered, so GAP lasts exactly POLL_GAP cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt  <= '0;
      attempts <= '0;
    end else begin
      if (gap_load) begin
        gap_cnt <= GAP_W'(POLL_GAP - 1);
      end else if (gap_run && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end

      if (clr) begin
        attempts <= '0;
      end else if (inc && attempts != CNT_W'(POLL_MAX)) begin
        attempts <= attempts + 1'b1;
      end
    end
  end

  assign gap_done           = (gap_cnt == '0);
  // The read being completed now is the final permitted attempt.
  assign last_attempt       = (attempts == CNT_W'(POLL_MAX - 1));
  assign attempts_exhausted = (attempts == CNT_W'(POLL_MAX));

endmodule

// File: rtl/platform_pio_master.sv
// Avalon-MM initiator for the 2-bit PIO slave: WRITE / READ / POLL commands, one outstanding.
// Accept->rsp_valid: WRITE 2, READ 3, BADOP 1 cycles; response held until rsp_ready, cmd_ready only in IDLE.
module platform_pio_master
  import platform_pio_pkg::*;
#(
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 32,
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic              busy,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata
);

  state_e            state;
  op_e               op_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mask_q;

  logic accept;
  logic poll_rd;
  logic rd_match;
  logic gap_done;
  logic last_attempt;
  logic attempts_exhausted;

  assign accept   = (state == S_IDLE) && cmd_valid;
  assign poll_rd  = (state == S_RD_C) && (op_q == OP_POLL);
  assign rd_match = (((avm_readdata ^ data_q) & mask_q) == '0);

  platform_pio_poll_timer #(
    .POLL_GAP (POLL_GAP),
    .POLL_MAX (POLL_MAX)
  ) u_poll_timer (
    .clk                (clk),
    .reset_n            (reset_n),
    .clr                (accept),
    .inc                (poll_rd),
    .gap_load           (state == S_RD_C),
    .gap_run            (state == S_GAP),
    .gap_done           (gap_done),
    .last_attempt       (last_attempt),
    .attempts_exhausted (attempts_exhausted)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      op_q           <= OP_WRITE;
      data_q         <= '0;
      mask_q         <= '0;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_status     <= ST_OK;
      busy           <= 1'b0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q      <= op_e'(cmd_op);
            data_q    <= cmd_data;
            mask_q    <= cmd_mask;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            case (op_e'(cmd_op))
              OP_WRITE: begin
                state          <= S_WR;
                avm_address    <= cmd_addr;
                avm_writedata  <= cmd_data;
                avm_chipselect <= 1'b1;
                avm_write_n    <= 1'b0;
              end
              OP_READ, OP_POLL: begin
                state          <= S_RD_A;
                avm_address    <= cmd_addr;
                avm_chipselect <= 1'b1;
              end
              default: begin
                state      <= S_RESP;
                rsp_valid  <= 1'b1;
                rsp_data   <= '0;
                rsp_status <= ST_BADOP;
              end
            endcase
          end
        end

        S_WR: begin
          state          <= S_RESP;
          avm_chipselect <= 1'b0;
          avm_write_n    <= 1'b1;
          rsp_valid      <= 1'b1;
          rsp_data       <= data_q;
          rsp_status     <= ST_OK;
        end

        S_RD_A: begin
          state <= S_RD_C;
        end

        // Slave readdata is valid here; capture it whatever the outcome so a timeout reports the last pins.
        S_RD_C: begin
          avm_chipselect <= 1'b0;
          rsp_data       <= avm_readdata;
          if (op_q != OP_POLL || rd_match) begin
            state      <= S_RESP;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_OK;
          end else if (last_attempt || attempts_exhausted) begin
            state      <= S_RESP;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_TIMEOUT;
          end else begin
            state <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_done) begin
            state          <= S_RD_A;
            avm_chipselect <= 1'b1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_platform_pio_master.sv
// Bench: two masters (default POLL_MAX and POLL_MAX=3) sharing one behavioural 2-bit bidirectional PIO slave.
module tb_platform_pio_master;
  import platform_pio_pkg::*;

  localparam int AW  = 2;
  localparam int DW  = 32;
  localparam int GAP = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic          use_b     = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op    = 2'b00;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_data  = '0;
  logic [DW-1:0] cmd_mask  = '0;
  logic          rsp_ready = 1'b0;
  logic          a_cmd_valid, b_cmd_valid;

  logic          a_cmd_ready, a_rsp_valid, a_busy, a_cs, a_wn;
  logic [DW-1:0] a_rsp_data, a_wdata;
  logic [1:0]    a_rsp_status;
  logic [AW-1:0] a_addr;
  logic          b_cmd_ready, b_rsp_valid, b_busy, b_cs, b_wn;
  logic [DW-1:0] b_rsp_data, b_wdata;
  logic [1:0]    b_rsp_status;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] slave_rd = '0;

  assign a_cmd_valid = cmd_valid & ~use_b;
  assign b_cmd_valid = cmd_valid & use_b;

  platform_pio_master #(.ADDR_W(AW), .DATA_W(DW), .POLL_GAP(GAP), .POLL_MAX(1000)) dut_a (
    .clk(clk), .reset_n(reset_n), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data), .rsp_status(a_rsp_status),
    .busy(a_busy), .avm_address(a_addr), .avm_chipselect(a_cs), .avm_write_n(a_wn),
    .avm_writedata(a_wdata), .avm_readdata(slave_rd)
  );

  platform_pio_master #(.ADDR_W(AW), .DATA_W(DW), .POLL_GAP(GAP), .POLL_MAX(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data), .rsp_status(b_rsp_status),
    .busy(b_busy), .avm_address(b_addr), .avm_chipselect(b_cs), .avm_write_n(b_wn),
    .avm_writedata(b_wdata), .avm_readdata(slave_rd)
  );

  logic          cur_cmd_ready, cur_rsp_valid, cur_busy, s_cs, s_wn;
  logic [DW-1:0] cur_rsp_data, s_wdata;
  logic [1:0]    cur_rsp_status;
  logic [AW-1:0] s_addr;
  assign cur_cmd_ready  = use_b ? b_cmd_ready  : a_cmd_ready;
  assign cur_rsp_valid  = use_b ? b_rsp_valid  : a_rsp_valid;
  assign cur_busy       = use_b ? b_busy       : a_busy;
  assign cur_rsp_data   = use_b ? b_rsp_data   : a_rsp_data;
  assign cur_rsp_status = use_b ? b_rsp_status : a_rsp_status;
  assign s_cs           = use_b ? b_cs         : a_cs;
  assign s_wn           = use_b ? b_wn         : a_wn;
  assign s_wdata        = use_b ? b_wdata      : a_wdata;
  assign s_addr         = use_b ? b_addr       : a_addr;

  // PIO slave model: output/direction registers, pins resolved against a weak external driver.
  logic [1:0] pio_data = 2'b00;
  logic [1:0] pio_dir  = 2'b00;
  logic [1:0] ext_pins = 2'b00;
  logic [1:0] pins;
  assign pins = (pio_dir & pio_data) | (~pio_dir & ext_pins);

  always @(posedge clk) begin
    if (s_cs && !s_wn) begin
      if (s_addr == REG_DATA) pio_data <= s_wdata[1:0];
      if (s_addr == REG_DIR)  pio_dir  <= s_wdata[1:0];
    end
    slave_rd <= (s_addr == REG_DATA) ? {30'd0, pins} :
                (s_addr == REG_DIR)  ? {30'd0, pio_dir} : '0;
  end

  int   cyc = 0, wn_low_cnt = 0, cs_cnt = 0, bad_cs = 0;
  int   rd_q[$];
  logic prev_cs = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (!s_wn) wn_low_cnt++;
    if (s_cs) cs_cnt++;
    if ((s_cs && (cur_cmd_ready || cur_rsp_valid)) || (!s_wn && !s_cs)) bad_cs++;
    if (s_cs && s_wn && !prev_cs) rd_q.push_back(cyc);
    prev_cs = s_cs;
  end

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          use_b;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
    logic [1:0]    ext0;
    int            ext_at;
    logic [1:0]    ext1;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_st;
    int            exp_lat;
    int            exp_reads;
    logic [1:0]    exp_pins;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    st;
    int            lat;
    int            wn;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[11];

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   lat;
    int   wn0;
    use_b    = v.use_b;
    ext_pins = v.ext0;
    e = '{v.exp_data, v.exp_st, v.exp_lat, (v.op == OP_WRITE) ? 1 : 0};
    sb_q.push_back(e);
    rd_q.delete();
    wn0 = wn_low_cnt;
    cmd_op = v.op; cmd_addr = v.addr; cmd_data = v.data; cmd_mask = v.mask; rsp_ready = 1'b1;
    chk($sformatf("v%0d_cmd_ready", idx), 32'(cur_cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!cur_rsp_valid && lat < 300) begin
      if (v.ext_at != 0 && lat == v.ext_at) ext_pins = v.ext1;
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    chk($sformatf("v%0d_rsp_data", idx), cur_rsp_data, e.data);
    chk($sformatf("v%0d_rsp_status", idx), 32'(cur_rsp_status), 32'(e.st));
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(e.lat));
    @(posedge clk); #1;
    chk($sformatf("v%0d_write_strobes", idx), 32'(wn_low_cnt - wn0), 32'(e.wn));
    chk($sformatf("v%0d_read_phases", idx), 32'(rd_q.size()), 32'(v.exp_reads));
    for (int i = 1; i < rd_q.size(); i++)
      chk($sformatf("v%0d_read_spacing%0d", idx, i), 32'(rd_q[i] - rd_q[i-1]), 32'(GAP + 2));
    chk($sformatf("v%0d_pins", idx), 32'(pins), 32'(v.exp_pins));
    chk($sformatf("v%0d_idle_after", idx), 32'({cur_cmd_ready, cur_busy, cur_rsp_valid}), 32'(3'b100));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cs0;
    logic stable;
    //           b  op        addr      data   mask  ext0   at  ext1   exp    status      lat rd pins
    vecs[0]  = '{0, OP_WRITE, REG_DIR,  32'h3, 32'h0, 2'b00, 0, 2'b00, 32'h3, ST_OK,       2, 0, 2'b00};
    vecs[1]  = '{0, OP_WRITE, REG_DATA, 32'h2, 32'h0, 2'b00, 0, 2'b00, 32'h2, ST_OK,       2, 0, 2'b10};
    vecs[2]  = '{0, OP_READ,  REG_DIR,  32'h0, 32'h0, 2'b00, 0, 2'b00, 32'h3, ST_OK,       3, 1, 2'b10};
    vecs[3]  = '{0, OP_READ,  REG_DATA, 32'h0, 32'h0, 2'b00, 0, 2'b00, 32'h2, ST_OK,       3, 1, 2'b10};
    vecs[4]  = '{0, OP_POLL,  REG_DATA, 32'h2, 32'h2, 2'b00, 0, 2'b00, 32'h2, ST_OK,       3, 1, 2'b10};
    vecs[5]  = '{0, OP_POLL,  REG_DIR,  32'h0, 32'h0, 2'b00, 0, 2'b00, 32'h3, ST_OK,       3, 1, 2'b10};
    vecs[6]  = '{0, OP_WRITE, REG_DIR,  32'h0, 32'h0, 2'b00, 0, 2'b00, 32'h0, ST_OK,       2, 0, 2'b00};
    vecs[7]  = '{0, OP_POLL,  REG_DATA, 32'h1, 32'h1, 2'b00, 20, 2'b01, 32'h1, ST_OK,     27, 5, 2'b01};
    vecs[8]  = '{1, OP_POLL,  REG_DATA, 32'h3, 32'h3, 2'b00, 10, 2'b01, 32'h1, ST_TIMEOUT, 15, 3, 2'b01};
    vecs[9]  = '{0, OP_WRITE, REG_DATA, 32'h1, 32'h0, 2'b10, 0, 2'b10, 32'h1, ST_OK,       2, 0, 2'b10};
    vecs[10] = '{0, OP_READ,  REG_DATA, 32'h0, 32'h0, 2'b10, 0, 2'b10, 32'h2, ST_OK,       3, 1, 2'b10};

    #2 reset_n = 1'b0;
    #1;
    chk("rst_ctrl_a", 32'({a_rsp_valid, a_busy, a_cs, a_wn, a_addr, a_rsp_status}), 32'(8'b0001_0000));
    chk("rst_ctrl_b", 32'({b_rsp_valid, b_busy, b_cs, b_wn, b_addr, b_rsp_status}), 32'(8'b0001_0000));
    chk("rst_data_a", a_rsp_data | a_wdata, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", 32'({a_cmd_ready, b_cmd_ready}), 32'(2'b11));

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset while a non-matching poll sits in GAP.
    use_b = 1'b0; ext_pins = 2'b00; rsp_ready = 1'b1;
    cmd_op = OP_POLL; cmd_addr = REG_DIR; cmd_data = 32'h3; cmd_mask = 32'h3;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("gap_state", 32'({a_busy, a_cs, a_wn, a_rsp_valid, a_addr}), 32'(6'b1010_01));
    reset_n = 1'b0;
    #1;
    chk("midrst_ctrl", 32'({a_rsp_valid, a_busy, a_cs, a_wn, a_addr, a_rsp_status}), 32'(8'b0001_0000));
    chk("midrst_wdata", a_wdata, 32'h0);
    chk("midrst_rsp_data", a_rsp_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[10], 10);

    // Reserved opcode with a stalled consumer.
    use_b = 1'b0; cmd_op = OP_RSVD; cmd_addr = REG_DIR; cmd_data = 32'hFFFF_FFFF; rsp_ready = 1'b0;
    cs0 = cs_cnt;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("badop_valid", 32'(a_rsp_valid), 32'd1);
    chk("badop_status", 32'(a_rsp_status), 32'(ST_BADOP));
    chk("badop_data", a_rsp_data, 32'h0);
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!(a_rsp_valid && a_rsp_status == ST_BADOP && a_rsp_data == '0 && !a_cmd_ready && a_busy))
        stable = 1'b0;
    end
    chk("badop_stable_stall", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("badop_release", 32'({a_rsp_valid, a_cmd_ready, a_busy}), 32'(3'b010));
    chk("badop_no_chipselect", 32'(cs_cnt - cs0), 32'd0);

    chk("bus_protocol_violations", 32'(bad_cs), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
